// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int MD_WIDTH = 32;
  localparam int MD_ITER  = 32;

  // The single dividend/divisor pair whose quotient does not fit in signed 32 bits
  localparam logic [MD_WIDTH-1:0] MD_DIV_OVF = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } md_state_t;

  // Unsigned magnitude; 0x80000000 maps to 2^31, which still fits unsigned
  function automatic logic [MD_WIDTH-1:0] magnitude(input logic [MD_WIDTH-1:0] v);
    return v[MD_WIDTH-1] ? -v : v;
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// 6-bit iteration counter; last flags the final iteration of an operation.
module multdiv_counter #(
  parameter int ITER = 32
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last
);

  logic [5:0] count_reg;

  assign last = (count_reg == 6'(ITER - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      count_reg <= '0;
    else if (clear)
      count_reg <= '0;
    else if (enable)
      count_reg <= last ? 6'd0 : count_reg + 6'd1;
  end

endmodule

// File: rtl/seq_multdiv_unit.sv
// Iterative signed multiply (radix-2 Booth) / divide (restoring) unit
// with a fixed 32-iteration latency and restart-on-start semantics.
module seq_multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = MD_ITER
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_mult,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  md_state_t state_reg, state_next;
  logic start, run, mul_en, div_en, last;

  // Booth accumulator; hi carries one guard bit so that subtracting a
  // multiplicand of -2^31 cannot wrap.
  logic [WIDTH-1:0] mcand_reg, lo_reg, lo_next;
  logic [WIDTH:0]   hi_reg, hi_next, sum;
  logic             qm1_reg, qm1_next, mul_ovf;
  logic [WIDTH+1:0] ovf_bits;

  logic [WIDTH-1:0] dvsr_reg, rem_reg, rem_next, quot_reg, quot_next, div_q;
  logic [WIDTH:0]   shifted, trial;
  logic             q_neg_reg, b_zero_reg, d_ovf_reg, ge;

  logic [WIDTH-1:0] result_reg;
  logic             exc_reg, rdy_reg;

  assign start = ctrl_mult | ctrl_div;

  multdiv_counter #(.ITER(ITER)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (start),
    .enable (run),
    .last   (last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (ctrl_mult)
      state_next = RUN_MUL;
    else if (ctrl_div)
      state_next = RUN_DIV;
    else if (state_reg != IDLE && last)
      state_next = IDLE;
  end

  always_comb begin
    run    = (state_reg != IDLE);
    mul_en = (state_reg == RUN_MUL);
    div_en = (state_reg == RUN_DIV);
    busy   = run | rdy_reg;
  end

  always_comb begin
    sum = hi_reg;
    case ({lo_reg[0], qm1_reg})
      2'b01:   sum = hi_reg + {mcand_reg[WIDTH-1], mcand_reg};
      2'b10:   sum = hi_reg - {mcand_reg[WIDTH-1], mcand_reg};
      default: sum = hi_reg;
    endcase
    hi_next  = {sum[WIDTH], sum[WIDTH:1]};
    lo_next  = {sum[0], lo_reg[WIDTH-1:1]};
    qm1_next = lo_reg[0];
    // Product fits in signed 32 bits only if everything above bit 30 is sign
    ovf_bits = {hi_next, lo_next[WIDTH-1]};
    mul_ovf  = !((&ovf_bits) || !(|ovf_bits));
  end

  always_comb begin
    shifted   = {rem_reg, quot_reg[WIDTH-1]};
    trial     = shifted - {1'b0, dvsr_reg};
    ge        = !trial[WIDTH];
    rem_next  = ge ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_next = {quot_reg[WIDTH-2:0], ge};
    div_q     = q_neg_reg ? -quot_next : quot_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_reg  <= '0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      qm1_reg    <= 1'b0;
      dvsr_reg   <= '0;
      rem_reg    <= '0;
      quot_reg   <= '0;
      q_neg_reg  <= 1'b0;
      b_zero_reg <= 1'b0;
      d_ovf_reg  <= 1'b0;
    end else if (start) begin
      mcand_reg  <= data_operandA;
      hi_reg     <= '0;
      lo_reg     <= data_operandB;
      qm1_reg    <= 1'b0;
      dvsr_reg   <= magnitude(data_operandB);
      rem_reg    <= '0;
      quot_reg   <= magnitude(data_operandA);
      q_neg_reg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      b_zero_reg <= (data_operandB == '0);
      d_ovf_reg  <= (data_operandA == MD_DIV_OVF) && (&data_operandB);
    end else if (mul_en) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      qm1_reg <= qm1_next;
    end else if (div_en) begin
      rem_reg  <= rem_next;
      quot_reg <= quot_next;
    end
  end

  // Completion still reports when a new start lands on the final edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      result_reg <= '0;
      exc_reg    <= 1'b0;
      rdy_reg    <= 1'b0;
    end else begin
      rdy_reg <= run && last;
      if (mul_en && last) begin
        result_reg <= lo_next;
        exc_reg    <= mul_ovf;
      end else if (div_en && last) begin
        result_reg <= b_zero_reg ? '0 : div_q;
        exc_reg    <= b_zero_reg | d_ovf_reg;
      end
    end
  end

  assign data_result    = result_reg;
  assign data_exception = exc_reg;
  assign data_resultRDY = rdy_reg;

endmodule

// File: tb/tb_seq_multdiv_unit.sv
// Scoreboard bench: the driver queues hand-computed results with their
// required RDY cycle, and a monitor checks each RDY pulse against the queue.
module tb_seq_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_mult = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  seq_multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .ctrl_div       (ctrl_div),
    .data_operandA  (opa),
    .data_operandB  (opb),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cyc;
  } exp_t;

  typedef struct {
    bit          mul;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        e;
  } vec_t;

  exp_t sb[$];
  vec_t vt[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_vec++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Called at a negedge; the following posedge is the start edge. Returns at the next negedge.
  task automatic issue(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [31:0] r, input logic e);
    exp_t x;
    ctrl_mult = mul;
    ctrl_div  = !mul;
    opa = a;
    opb = b;
    if (push) begin
      x.res = r;
      x.exc = e;
      x.cyc = cyc + 33;
      sb.push_back(x);
    end
    @(negedge clock);
    ctrl_mult = 1'b0;
    ctrl_div  = 1'b0;
    opa = $urandom;
    opb = $urandom;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin
      @(negedge clock);
      t++;
    end
    if (t >= 100) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: busy=%b pending=%0d after %0d cycles, required idle", busy, sb.size(), t);
    end
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    exp_t x;
    if (reset && data_resultRDY) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rdy: got pulse with result %h at cycle %0d, required none", data_result, cyc);
      end else begin
        x = sb.pop_front();
        $display("rdy cycle %0d result %h exc %b", cyc, data_result, data_exception);
        check("rdy_cycle", 32'(cyc), 32'(x.cyc));
        check("result", data_result, x.res);
        check("exception", {31'b0, data_exception}, {31'b0, x.exc});
        check("busy_at_rdy", {31'b0, busy}, 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    wait_cycles(3);
    check("reset_result", data_result, 32'd0);
    check("reset_exc", {31'b0, data_exception}, 32'd0);
    check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    reset = 1'b1;
    wait_cycles(2);

    // 7 * -3 with explicit busy/RDY timing around the start edge S
    issue(1, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, 1'b0);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    wait_cycles(31);
    check("rdy_before_s32", {31'b0, data_resultRDY}, 32'd0);
    check("busy_before_s32", {31'b0, busy}, 32'd1);
    wait_cycles(2);
    check("busy_after_s33", {31'b0, busy}, 32'd0);
    check("rdy_after_s33", {31'b0, data_resultRDY}, 32'd0);

    vt.push_back('{1'b1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1});
    vt.push_back('{1'b1, 32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 1'b0});
    vt.push_back('{1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1});
    vt.push_back('{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0});
    vt.push_back('{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vt.push_back('{1'b0, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 1'b0});
    vt.push_back('{1'b0, 32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0});
    vt.push_back('{1'b0, 32'd100,       32'd7,         32'd14,        1'b0});
    vt.push_back('{1'b0, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0});
    vt.push_back('{1'b0, 32'd5,         32'd0,         32'd0,         1'b1});
    vt.push_back('{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1});
    vt.push_back('{1'b0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0});
    vt.push_back('{1'b0, 32'd7,         32'd100,       32'd0,         1'b0});
    foreach (vt[i]) begin
      issue(vt[i].mul, vt[i].a, vt[i].b, 1, vt[i].r, vt[i].e);
      wait_idle();
    end

    // New start on the completion edge of the previous operation
    issue(1, 32'd6, 32'd7, 1, 32'd42, 1'b0);
    wait_cycles(31);
    issue(0, 32'd50, 32'd5, 1, 32'd10, 1'b0);
    wait_idle();
    wait_cycles(5);
    check("hold_result", data_result, 32'd10);

    // Restart at S+10: only the divide may report
    issue(1, 32'd3, 32'd4, 0, 32'd0, 1'b0);
    wait_cycles(9);
    issue(0, 32'd20, 32'd5, 1, 32'd4, 1'b0);
    wait_idle();

    // Reset pulse mid-multiply: outputs clear at once, no RDY follows
    issue(1, 32'd3, 32'd4, 0, 32'd0, 1'b0);
    wait_cycles(15);
    reset = 1'b0;
    #1;
    check("midreset_result", data_result, 32'd0);
    check("midreset_exc", {31'b0, data_exception}, 32'd0);
    check("midreset_rdy", {31'b0, data_resultRDY}, 32'd0);
    check("midreset_busy", {31'b0, busy}, 32'd0);
    #3 reset = 1'b1;
    wait_cycles(40);
    issue(1, 32'd9, 32'hFFFF_FFFE, 1, 32'hFFFF_FFEE, 1'b0);
    wait_idle();

    check("pending_expectations", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
